// File: rtl/lemming_pkg.sv
// Shared definitions for the lemming playfield and its walker FSM.
// Used by lemming_step_timer and lemming_world.
package lemming_pkg;

    // Default playfield geometry and step rate
    localparam int DEF_ARENA_W  = 16;
    localparam int DEF_STEP_DIV = 4;

    // Direction encoding shared with the walker FSM
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // World FSM: frozen or stepping
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } world_state_t;

endpackage

// File: rtl/lemming_step_timer.sv
// Step-rate divider with the IDLE/RUN world FSM.
// tick is high on the last divider count of each period while running.
module lemming_step_timer
    import lemming_pkg::*;
#(
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic clk,
    input  logic areset,
    input  logic run,
    output logic tick
);

    localparam int                CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);

    world_state_t     state, state_next;
    logic [CNT_W-1:0] count, count_next;

    // State and divider registers
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state, divider advance and tick decode
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which would infer a latch.
        state_next = state;
        count_next = count;
        tick       = 1'b0;
        case (state)
            ST_IDLE: begin
                count_next = '0;
                if (run) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!run) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else begin
                    tick       = (count == CNT_LAST);
                    count_next = tick ? '0 : count + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/lemming_world.sv
// Playfield model for one lemming: position counter, wall/obstacle bumps,
// placement override and protocol-error flag.
// Optional obstacle register enabled by defining LEMMING_OBSTACLE_EN.
module lemming_world
    import lemming_pkg::*;
#(
    parameter int ARENA_W  = DEF_ARENA_W,
    parameter int STEP_DIV = DEF_STEP_DIV,
    parameter int POS_W    = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             run,
    input  logic             walk_left,
    input  logic             walk_right,
    input  logic             place_valid,
    input  logic [POS_W-1:0] place_pos,
    input  logic             obst_valid,
    input  logic [POS_W-1:0] obst_pos,
    output logic             bump_left,
    output logic             bump_right,
    output logic [POS_W-1:0] pos,
    output logic             step_tick,
    output logic             proto_err
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(ARENA_W - 1);

    logic             tick;
    logic [POS_W-1:0] target_left, target_right, place_clamped;
    logic             hit_left, hit_right;
    logic [POS_W-1:0] pos_next;
    logic             bump_left_next, bump_right_next, proto_err_next;

    lemming_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .clk    (clk),
        .areset (areset),
        .run    (run),
        .tick   (tick)
    );

    assign target_left   = pos - POS_W'(1);
    assign target_right  = pos + POS_W'(1);
    assign place_clamped = (int'(place_pos) >= ARENA_W) ? LAST_POS : place_pos;

`ifdef LEMMING_OBSTACLE_EN
    logic             obst_vld_q;
    logic [POS_W-1:0] obst_cell_q;

    // Obstacle register; out-of-arena cells load as invalid
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            obst_vld_q  <= 1'b0;
            obst_cell_q <= '0;
        end else if (obst_valid) begin
            obst_vld_q  <= (int'(obst_pos) < ARENA_W);
            obst_cell_q <= obst_pos;
        end
    end

    assign hit_left  = obst_vld_q && (obst_cell_q == target_left);
    assign hit_right = obst_vld_q && (obst_cell_q == target_right);
`else
    // Obstacle ports are kept for a uniform interface but have no effect
    wire unused_obst = ^{obst_valid, obst_pos};

    assign hit_left  = 1'b0;
    assign hit_right = 1'b0;
`endif

    // Step evaluation on a tick; placement overrides the move and any bump
    always_comb begin
        pos_next        = pos;
        bump_left_next  = 1'b0;
        bump_right_next = 1'b0;
        proto_err_next  = proto_err;
        if (tick) begin
            if (walk_left == walk_right) begin
                proto_err_next = 1'b1;
            end else if (walk_left) begin
                if (pos == '0 || hit_left) bump_left_next = 1'b1;
                else                       pos_next       = target_left;
            end else begin
                if (pos == LAST_POS || hit_right) bump_right_next = 1'b1;
                else                              pos_next        = target_right;
            end
        end
        if (place_valid) begin
            pos_next        = place_clamped;
            bump_left_next  = 1'b0;
            bump_right_next = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pos        <= '0;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            step_tick  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            pos        <= pos_next;
            bump_left  <= bump_left_next;
            bump_right <= bump_right_next;
            step_tick  <= tick;
            proto_err  <= proto_err_next;
        end
    end

endmodule

// File: tb/tb_lemming_world.sv
// Directed self-checking bench for lemming_world (ARENA_W=16, STEP_DIV=4, POS_W=5
// so that out-of-arena placements can be driven). Includes a small walker model
// for the closed-loop case.
module tb_lemming_world;
    import lemming_pkg::*;

    localparam int ARENA_W  = 16;
    localparam int STEP_DIV = 4;
    localparam int POS_W    = 5;

    typedef struct {
        int pos;
        int bl;
        int br;
    } exp_t;

    logic             clk = 1'b0;
    logic             areset = 1'b1;
    logic             run = 1'b0;
    logic             man_left = 1'b0, man_right = 1'b0;
    logic             closed = 1'b0;
    logic             start_heading = DIR_RIGHT;
    logic             heading;
    logic             walk_left, walk_right;
    logic             place_valid = 1'b0;
    logic [POS_W-1:0] place_pos = '0;
    logic             obst_valid = 1'b0;
    logic [POS_W-1:0] obst_pos = '0;
    logic             bump_left, bump_right, step_tick, proto_err;
    logic [POS_W-1:0] pos;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lemming_world #(
        .ARENA_W  (ARENA_W),
        .STEP_DIV (STEP_DIV),
        .POS_W    (POS_W)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .run         (run),
        .walk_left   (walk_left),
        .walk_right  (walk_right),
        .place_valid (place_valid),
        .place_pos   (place_pos),
        .obst_valid  (obst_valid),
        .obst_pos    (obst_pos),
        .bump_left   (bump_left),
        .bump_right  (bump_right),
        .pos         (pos),
        .step_tick   (step_tick),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    // Walker model: turns on the edge after it sees a bump
    always @(posedge clk) begin
        if (!closed)         heading <= start_heading;
        else if (bump_left)  heading <= DIR_RIGHT;
        else if (bump_right) heading <= DIR_LEFT;
    end

    assign walk_left  = closed ? (heading == DIR_LEFT)  : man_left;
    assign walk_right = closed ? (heading == DIR_RIGHT) : man_right;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int p, input int bl, input int br);
        exp_t e;
        e.pos = p;
        e.bl  = bl;
        e.br  = br;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the next step_tick and compare against the scoreboard head
    task automatic wait_step(input string tag);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (step_tick) seen = 1'b1;
        end
        check({tag, " step_tick seen"}, 32'(seen), 32'd1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " pos"},        32'(pos),        32'(e.pos));
            check({tag, " bump_left"},  32'(bump_left),  32'(e.bl));
            check({tag, " bump_right"}, 32'(bump_right), 32'(e.br));
            check({tag, " bumps exclusive"}, 32'(bump_left & bump_right), 32'd0);
        end
    endtask

    task automatic do_reset();
        areset      = 1'b1;
        run         = 1'b0;
        man_left    = 1'b0;
        man_right   = 1'b0;
        closed      = 1'b0;
        place_valid = 1'b0;
        obst_valid  = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("reset pos",        32'(pos),        32'd0);
        check("reset bump_left",  32'(bump_left),  32'd0);
        check("reset bump_right", 32'(bump_right), 32'd0);
        check("reset step_tick",  32'(step_tick),  32'd0);
        check("reset proto_err",  32'(proto_err),  32'd0);
        areset = 1'b0;

        // Walk left from 2 into the wall
        place_valid = 1'b1; place_pos = 5'd2; man_left = 1'b1; run = 1'b1;
        push_exp(1, 0, 0); push_exp(0, 0, 0); push_exp(0, 1, 0);
        @(negedge clk);
        place_valid = 1'b0;
        check("placed pos 2", 32'(pos), 32'd2);
        wait_step("left1");
        wait_step("left2");
        wait_step("left3");
        @(negedge clk);
        check("bump_left one cycle", 32'(bump_left), 32'd0);
        check("pos held at 0",       32'(pos),       32'd0);

        // Closed loop with the walker, from 14 heading right
        do_reset();
        start_heading = DIR_RIGHT;
        @(negedge clk);
        place_valid = 1'b1; place_pos = 5'd14; closed = 1'b1; run = 1'b1;
        push_exp(15, 0, 0); push_exp(15, 0, 1); push_exp(14, 0, 0); push_exp(13, 0, 0);
        @(negedge clk);
        place_valid = 1'b0;
        wait_step("loop1");
        wait_step("loop2");
        wait_step("loop3");
        wait_step("loop4");

        // Obstacle at 5, start at 3 heading right
        do_reset();
        obst_valid = 1'b1; obst_pos = 5'd5;
        place_valid = 1'b1; place_pos = 5'd3; man_right = 1'b1; run = 1'b1;
`ifdef LEMMING_OBSTACLE_EN
        push_exp(4, 0, 0); push_exp(4, 0, 1);
`else
        push_exp(4, 0, 0); push_exp(5, 0, 0);
`endif
        @(negedge clk);
        obst_valid = 1'b0; place_valid = 1'b0;
        wait_step("obst1");
        wait_step("obst2");

        // Both directions on a tick: no move, sticky proto_err
        do_reset();
        place_valid = 1'b1; place_pos = 5'd7; man_left = 1'b1; man_right = 1'b1; run = 1'b1;
        push_exp(7, 0, 0);
        @(negedge clk);
        place_valid = 1'b0;
        wait_step("both");
        check("proto_err set", 32'(proto_err), 32'd1);
        man_left = 1'b0;
        push_exp(8, 0, 0);
        wait_step("after both");
        check("proto_err sticky", 32'(proto_err), 32'd1);
        do_reset();
        check("proto_err cleared by reset", 32'(proto_err), 32'd0);

        // Placement on a bumping tick suppresses the bump; clamp of out-of-arena place
        run = 1'b1; man_left = 1'b1;
        repeat (4) @(negedge clk);
        place_valid = 1'b1; place_pos = 5'd9;
        push_exp(9, 0, 0);
        wait_step("place on tick");
        place_valid = 1'b0;
        push_exp(8, 0, 0);
        wait_step("after place");
        place_valid = 1'b1; place_pos = 5'd20;
        @(negedge clk);
        place_valid = 1'b0;
        check("place clamp", 32'(pos), 32'd15);

        // areset on a bumping tick at pos 0 heading left
        do_reset();
        run = 1'b1; man_left = 1'b1; man_right = 1'b1;
        push_exp(0, 0, 0);
        wait_step("pre-reset both");
        check("pre-reset proto_err", 32'(proto_err), 32'd1);
        man_right = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        #1;
        check("areset pos",       32'(pos),       32'd0);
        check("areset step_tick", 32'(step_tick), 32'd0);
        check("areset proto_err", 32'(proto_err), 32'd0);
        @(negedge clk);
        check("areset no bump_left", 32'(bump_left), 32'd0);
        areset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
